spi_reg_bank: RTL and testbench
===============================

Name: spi_reg_bank

Overview:
SPI slave plus frame-synchronous register bank feeding the sprite/colour datapath ahead of the SVGA pixel output. A host writes configuration bytes over SPI. Each byte lands in a staging array. The whole array is copied into the active array on the next frame boundary, so sprite updates never tear mid-frame. All SPI inputs are asynchronous and are oversampled in the pixel-clock domain.

Parameters:
NUM_REGS, 16, number of 8-bit registers; must be a power of 2, maximum 128
ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden
SYNC_STAGES, 2, flip-flop stages on each of spi_sclk/spi_mosi/spi_cs; minimum 2

Ports:
clk  in  1  pixel clock; all logic on the rising edge
reset_n  in  1  asynchronous, active-low reset
spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
spi_mosi  in  1  SPI data in, MSB first
spi_miso  out  1  SPI data out, MSB first
spi_cs  in  1  chip select, active-low
next_frame  in  1  one-clk pulse at the frame boundary, from the timing generator
regs_out  out  NUM_REGS*8  active registers; reg i is at bits [8i+7:8i]
reg_update  out  1  one-clk pulse, high in the cycle after an active-array copy
busy  out  1  high while a transaction is in progress (state != IDLE)

Behaviour:
- Reset: all staging and active registers = 0; dirty = 0; state = IDLE; spi_miso = 0; reg_update = 0; busy = 0.
- Input conditioning: spi_sclk, spi_mosi and spi_cs each pass through SYNC_STAGES flops. One further flop on sclk and cs provides edge detection. Host requirement: sclk high and low phases each >= 4 clk periods.
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD on synchronized cs falling edge; bit counter cleared to 0.
  - Any state -> IDLE on synchronized cs high, including mid-byte. A partial byte is discarded with no write.
- Shift in: on each synchronized sclk rising edge, shift the synchronized mosi into an 8-bit register and increment a 3-bit counter.
- CMD byte (bit counter wraps 7 -> 0):
  - bit7 = 1 means write, 0 means read.
  - bits[ADDR_W-1:0] = start address; the remaining bits are ignored.
  - Go to DATA.
- Write in DATA: each completed byte is written to staging[addr] and sets dirty. addr then increments, wrapping NUM_REGS-1 -> 0. Unlimited burst length.
- Read in DATA: see Optional Feature. Read bytes never modify staging or dirty.
- Frame commit: when next_frame = 1 and dirty = 1:
  - active <= staging, all registers in one cycle;
  - dirty <= 0;
  - reg_update = 1 in the next cycle.
  - If dirty = 0, next_frame is ignored and no pulse is generated.
- Commit with a transaction in progress: the commit happens anyway. Only completed bytes are included.
- Same-cycle collision (next_frame and a byte-write completion in the same cycle):
  - the copy uses pre-write staging;
  - the new byte lands in staging;
  - dirty stays 1, so the byte commits at the following frame.
- regs_out is driven only from the active array, never from staging.
- Reset mid-transfer returns to the reset state immediately; any transfer in flight is lost.

Optional Feature:
Macro SPI_READBACK_EN.
- Defined:
  - when a read CMD byte completes, an output shifter loads staging[addr] and drives its MSB on spi_miso immediately;
  - the shifter shifts on each synchronized sclk falling edge;
  - after each 8 bits, addr increments (same wrap rule) and the shifter reloads.
  - spi_miso = 0 whenever state != DATA or the command is a write.
- Not defined: spi_miso is tied to 0 and read commands are accepted but have no effect.

Test Plan:
- Write 0x83 then 0x5A (writes reg 3), then a next_frame pulse -> regs_out[31:24] = 0x5A one clk after next_frame; reg_update high for exactly 1 clk; all other registers 0.
- Burst: write command to address 15, data 0x11 0x22 0x33 -> staging[15]=0x11, [0]=0x22, [1]=0x33. Active array unchanged until next_frame, then all three visible together.
- Abort: write command to reg 2, 5 data bits, then cs high -> staging[2] stays 0. next_frame gives no reg_update (dirty = 0). Next transaction parses correctly from CMD.
- Collision: byte 0xA5 to reg 4 completes in the same clk as next_frame -> reg 4 not updated at that frame. It appears after the following next_frame, with a second reg_update pulse.
- Readback (SPI_READBACK_EN): after writing 0xC3 to reg 7, send read command 0x07 plus 8 clocks -> spi_miso bits 1,1,0,0,0,0,1,1 on successive rising sclk edges. Without the macro, spi_miso stays 0 throughout.
- Reset: assert reset_n low mid-way through a data byte, after a committed write -> regs_out = 0, busy = 0, spi_miso = 0. A fresh transaction after release works.

Source files
------------

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave feeding a staging register array that is copied to the active
// array on a frame boundary. Optional MISO readback enabled by SPI_READBACK_EN.
module spi_reg_bank #(
  parameter int NUM_REGS    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  input  logic                  spi_cs,
  input  logic                  next_frame,
  output logic [NUM_REGS*8-1:0] regs_out,
  output logic                  reg_update,
  output logic                  busy
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                   sclk_d1_q, cs_d1_q;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise, cs_fall;

  state_t              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [6:0]          shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                is_write_q, is_write_d;
  logic                dirty_q, dirty_d;
  logic                reg_update_q;

  logic [7:0]          byte_in;
  logic                cmd_done, data_done, wr_en, commit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_d1_q   <= 1'b0;
      cs_d1_q     <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      sclk_d1_q   <= sclk_s;
      cs_d1_q     <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d1_q;
  assign cs_fall   = ~cs_s & cs_d1_q;

  assign byte_in   = {shift_q, mosi_s};
  assign cmd_done  = ~cs_s && (state_q == CMD)  && sclk_rise && (bit_cnt_q == 3'd7);
  assign data_done = ~cs_s && (state_q == DATA) && sclk_rise && (bit_cnt_q == 3'd7);
  assign wr_en     = data_done & is_write_q;
  assign commit    = next_frame & dirty_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    is_write_d = is_write_q;
    if (cs_s) begin
      // Deselect aborts from any state; a partial byte is simply dropped.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d   = CMD;
            bit_cnt_d = 3'd0;
          end
        end
        CMD, DATA: begin
          if (sclk_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
          if (cmd_done) begin
            state_d    = DATA;
            is_write_d = byte_in[7];
            addr_d     = byte_in[ADDR_W-1:0];
          end else if (data_done) begin
            addr_d = addr_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A write completing alongside a commit lands in staging and keeps dirty set.
  assign dirty_d = (dirty_q & ~commit) | wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      addr_q       <= '0;
      is_write_q   <= 1'b0;
      dirty_q      <= 1'b0;
      reg_update_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      addr_q       <= addr_d;
      is_write_q   <= is_write_d;
      dirty_q      <= dirty_d;
      reg_update_q <= commit;
    end
  end

`ifdef SPI_READBACK_EN
  logic [NUM_REGS*8-1:0] staging_flat;
`endif

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [7:0] stage_q, act_q;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stage_q <= 8'd0;
          act_q   <= 8'd0;
        end else begin
          if (wr_en && (addr_q == ADDR_W'(gi))) stage_q <= byte_in;
          if (commit) act_q <= stage_q;
        end
      end
      assign regs_out[8*gi +: 8] = act_q;
`ifdef SPI_READBACK_EN
      assign staging_flat[8*gi +: 8] = stage_q;
`endif
    end
  endgenerate

`ifdef SPI_READBACK_EN
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] rd_addr;
  logic              sclk_fall;

  assign sclk_fall = ~sclk_s & sclk_d1_q;
  assign rd_addr   = cmd_done ? byte_in[ADDR_W-1:0] : addr_q + 1'b1;

  // The falling edge right after a load (bit counter at 0) must not shift,
  // otherwise the MSB would never be seen by the host's next rising edge.
  always_comb begin
    tx_d = tx_q;
    if ((cmd_done && !byte_in[7]) || (data_done && !is_write_q))
      tx_d = staging_flat[{rd_addr, 3'b000} +: 8];
    else if (sclk_fall && (bit_cnt_q != 3'd0))
      tx_d = {tx_q[6:0], 1'b0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_q <= 8'd0;
    else          tx_q <= tx_d;
  end

  assign spi_miso = (state_q == DATA) && !is_write_q && tx_q[7];
`else
  assign spi_miso = 1'b0;
`endif

  assign reg_update = reg_update_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: writes, bursts, abort, frame collision,
// readback and mid-transfer reset, all against hand-computed values.
`timescale 1ns/1ps
module tb_spi_reg_bank;
  localparam int NREGS = 16;
  localparam int HALF  = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic spi_sclk = 1'b0;
  logic spi_mosi = 1'b0;
  logic spi_cs = 1'b1;
  logic next_frame = 1'b0;
  logic spi_miso, reg_update, busy;
  logic [NREGS*8-1:0] regs_out;
  logic [7:0]  rx_byte;
  logic [15:0] rx16;
  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  spi_reg_bank #(.NUM_REGS(NREGS), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_cs     (spi_cs),
    .next_frame (next_frame),
    .regs_out   (regs_out),
    .reg_update (reg_update),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_start();
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic spi_stop();
    repeat (HALF) @(negedge clk);
    spi_cs = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  // collide: raise next_frame so it coincides with the cycle the last bit's
  // byte is written (two sync flops plus the edge-detect cycle).
  task automatic spi_bits(input logic [7:0] b, input int nbits, input bit collide,
                          output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      repeat (HALF) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      spi_sclk = 1'b1;
      if (collide && i == 0) begin
        @(negedge clk);
        @(negedge clk);
        next_frame = 1'b1;
        @(negedge clk);
        next_frame = 1'b0;
        check("collide_upd", reg_update, 1'b1);
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic spi_xfer(input logic [31:0] bytes, input int n, output logic [15:0] rx);
    logic [7:0] r;
    rx = 16'd0;
    spi_start();
    for (int k = 0; k < n; k++) begin
      spi_bits(bytes[31-8*k -: 8], 8, 1'b0, r);
      rx = {rx[7:0], r};
    end
    spi_stop();
    $display("spi txn: %0d bytes, cmd 0x%02h, last rx 0x%04h", n, bytes[31:24], rx);
  endtask

  task automatic frame(input string tag, input logic exp_upd, input logic [127:0] exp_regs);
    @(negedge clk);
    next_frame = 1'b1;
    check({tag, "_upd_pre"}, reg_update, 1'b0);
    @(negedge clk);
    next_frame = 1'b0;
    check({tag, "_upd"}, reg_update, exp_upd);
    check({tag, "_regs"}, regs_out, exp_regs);
    @(negedge clk);
    check({tag, "_upd_drop"}, reg_update, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_regs", regs_out, 128'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_miso", spi_miso, 1'b0);
    check("rst_upd", reg_update, 1'b0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single write to reg 3
    spi_xfer(32'h835A0000, 2, rx16);
    check("t1_busy", busy, 1'b0);
    check("t1_precommit", regs_out, 128'd0);
    frame("t1", 1'b1, 128'h5A000000);

    // Burst wrapping 15 -> 0 -> 1
    spi_xfer(32'h8F112233, 4, rx16);
    check("t2_precommit", regs_out, 128'h5A000000);
    frame("t2", 1'b1, 128'h11000000_00000000_00000000_5A003322);

    // Abort mid-byte to reg 2
    spi_start();
    spi_bits(8'h82, 8, 1'b0, rx_byte);
    spi_bits(8'hFF, 5, 1'b0, rx_byte);
    check("t3_busy_mid", busy, 1'b1);
    spi_stop();
    $display("spi txn: aborted write to reg 2 after 5 data bits");
    check("t3_busy_after", busy, 1'b0);
    frame("t3", 1'b0, 128'h11000000_00000000_00000000_5A003322);
    spi_xfer(32'h86770000, 2, rx16);
    frame("t3b", 1'b1, 128'h11000000_00000000_00770000_5A003322);

    // Collision: 0xA5 to reg 4 completes with next_frame
    spi_start();
    spi_bits(8'h83, 8, 1'b0, rx_byte);
    spi_bits(8'h44, 8, 1'b0, rx_byte);
    spi_bits(8'hA5, 8, 1'b1, rx_byte);
    check("t4_collide_regs", regs_out, 128'h11000000_00000000_00770000_44003322);
    spi_stop();
    $display("spi txn: write reg3=0x44 reg4=0xA5 with frame collision");
    frame("t4", 1'b1, 128'h11000000_00000000_007700A5_44003322);

    // Readback of reg 7 and reg 8
    spi_xfer(32'h87C33C00, 3, rx16);
    frame("t5w", 1'b1, 128'h11000000_0000003C_C37700A5_44003322);
    spi_xfer(32'h07000000, 3, rx16);
`ifdef SPI_READBACK_EN
    check("t5_readback", rx16, 16'hC33C);
`else
    check("t5_readback", rx16, 16'h0000);
`endif
    frame("t5r", 1'b0, 128'h11000000_0000003C_C37700A5_44003322);

    // Reset in the middle of a data byte
    spi_start();
    spi_bits(8'h81, 8, 1'b0, rx_byte);
    spi_bits(8'hF0, 4, 1'b0, rx_byte);
    check("t6_busy_mid", busy, 1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    spi_cs = 1'b1;
    spi_sclk = 1'b0;
    #1;
    check("t6_rst_regs", regs_out, 128'd0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_miso", spi_miso, 1'b0);
    check("t6_rst_upd", reg_update, 1'b0);
    $display("spi txn: reset asserted mid-byte");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    spi_xfer(32'h859C0000, 2, rx16);
    frame("t6", 1'b1, 128'h00000000_00000000_00009C00_00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
